regfile_wb_arbiter: RTL and testbench

REGFILE_WB_ARBITER -- requirements
Module: regfile_wb_arbiter

---
 rtl/regfile_wb_arbiter.sv | 133 +++++++++++++
 tb/tb_regfile_wb_arbiter.sv | 209 ++++++++++++++++++++
 2 files changed

// File: rtl/regfile_wb_arbiter.sv
// ============================================================================
// Module   : regfile_wb_arbiter
// Arbitrates the register-file write port between pipeline write-back and a
// buffered multi-cycle unit write; the buffered write is forced after MAX_WAIT
// deferrals. Optional macro ZERO_REG_SUPPRESS_EN masks writes to register 0.
// Revision : 1.0
// ============================================================================
`default_nettype none

module regfile_wb_arbiter #(
  parameter int REG_WIDTH = 32,
  parameter int ADDR_SIZE = 5,
  parameter int MAX_WAIT  = 4
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 wb_valid,
  input  logic [ADDR_SIZE-1:0] wb_addr,
  input  logic [REG_WIDTH-1:0] wb_data,
  input  logic                 mc_valid,
  output logic                 mc_ready,
  input  logic [ADDR_SIZE-1:0] mc_addr,
  input  logic [REG_WIDTH-1:0] mc_data,
  output logic                 pipe_stall,
  output logic                 mc_pending,
  output logic [ADDR_SIZE-1:0] mc_pending_addr,
  output logic                 RegWrite,
  output logic [ADDR_SIZE-1:0] write_register,
  output logic [REG_WIDTH-1:0] write_data
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    HOLD  = 2'd1,
    FORCE = 2'd2
  } state_t;

  localparam logic [3:0] c_max_wait = 4'(MAX_WAIT);

  state_t               r_state;
  state_t               w_state_nxt;
  logic [3:0]           r_wait_cnt;
  logic [3:0]           w_wait_cnt_nxt;
  logic [ADDR_SIZE-1:0] r_buf_addr;
  logic [REG_WIDTH-1:0] r_buf_data;
  logic                 w_capture;
  logic                 w_grant;
  logic                 w_we;
  logic [ADDR_SIZE-1:0] w_grant_addr;
  logic [REG_WIDTH-1:0] w_grant_data;

  always_comb begin
    w_state_nxt    = r_state;
    w_wait_cnt_nxt = r_wait_cnt;
    w_capture      = 1'b0;
    w_grant        = 1'b0;
    w_grant_addr   = wb_addr;
    w_grant_data   = wb_data;
    case (r_state)
      IDLE: begin
        w_grant = wb_valid;
        if (mc_valid) begin
          w_capture      = 1'b1;
          w_wait_cnt_nxt = 4'd0;
          w_state_nxt    = HOLD;
        end
      end
      HOLD: begin
        w_grant = 1'b1;
        if (!wb_valid) begin
          w_grant_addr = r_buf_addr;
          w_grant_data = r_buf_data;
          w_state_nxt  = IDLE;
        end else if (wb_addr == r_buf_addr) begin
          // Younger pipeline write to the same register supersedes the buffer
          w_state_nxt = IDLE;
        end else begin
          w_wait_cnt_nxt = r_wait_cnt + 4'd1;
          if (r_wait_cnt + 4'd1 == c_max_wait) begin
            w_state_nxt = FORCE;
          end
        end
      end
      FORCE: begin
        w_grant      = 1'b1;
        w_grant_addr = r_buf_addr;
        w_grant_data = r_buf_data;
        w_state_nxt  = IDLE;
      end
      default: begin
        w_state_nxt = IDLE;
      end
    endcase
  end

`ifdef ZERO_REG_SUPPRESS_EN
  assign w_we = w_grant && (w_grant_addr != '0);
`else
  assign w_we = w_grant;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state        <= IDLE;
      r_wait_cnt     <= 4'd0;
      r_buf_addr     <= '0;
      r_buf_data     <= '0;
      RegWrite       <= 1'b0;
      write_register <= '0;
      write_data     <= '0;
    end else begin
      r_state    <= w_state_nxt;
      r_wait_cnt <= w_wait_cnt_nxt;
      if (w_capture) begin
        r_buf_addr <= mc_addr;
        r_buf_data <= mc_data;
      end
      RegWrite <= w_we;
      if (w_grant) begin
        write_register <= w_grant_addr;
        write_data     <= w_grant_data;
      end
    end
  end

  assign mc_ready        = (r_state == IDLE);
  assign mc_pending      = (r_state != IDLE);
  assign pipe_stall      = (r_state == FORCE);
  assign mc_pending_addr = mc_pending ? r_buf_addr : '0;

endmodule

`default_nettype wire

// File: tb/tb_regfile_wb_arbiter.sv
// Directed bench for regfile_wb_arbiter: a pending-write model predicts every
// cycle's port and status outputs, plus literal expectations for key scenarios.
`default_nettype none

module tb_regfile_wb_arbiter;
  localparam int MAX_WAIT = 4;
`ifdef ZERO_REG_SUPPRESS_EN
  localparam bit SUPPRESS = 1'b1;
`else
  localparam bit SUPPRESS = 1'b0;
`endif

  logic        clk;
  logic        rst_n;
  logic        wb_valid;
  logic [4:0]  wb_addr;
  logic [31:0] wb_data;
  logic        mc_valid;
  logic        mc_ready;
  logic [4:0]  mc_addr;
  logic [31:0] mc_data;
  logic        pipe_stall;
  logic        mc_pending;
  logic [4:0]  mc_pending_addr;
  logic        RegWrite;
  logic [4:0]  write_register;
  logic [31:0] write_data;

  int checks = 0;
  int errors = 0;

  // model: at most one pending mc write and how often it was deferred
  bit          m_pend;
  logic [4:0]  m_addr;
  logic [31:0] m_data;
  int          m_defers;
  bit          e_grant, e_reset, e_we;
  logic [4:0]  e_addr;
  logic [31:0] e_data;

  regfile_wb_arbiter #(.REG_WIDTH(32), .ADDR_SIZE(5), .MAX_WAIT(MAX_WAIT)) dut (
    .clk(clk), .rst_n(rst_n),
    .wb_valid(wb_valid), .wb_addr(wb_addr), .wb_data(wb_data),
    .mc_valid(mc_valid), .mc_ready(mc_ready), .mc_addr(mc_addr), .mc_data(mc_data),
    .pipe_stall(pipe_stall), .mc_pending(mc_pending), .mc_pending_addr(mc_pending_addr),
    .RegWrite(RegWrite), .write_register(write_register), .write_data(write_data)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_step();
    e_grant = 1'b0;
    e_reset = 1'b0;
    if (!rst_n) begin
      m_pend = 1'b0; m_addr = '0; m_data = '0; m_defers = 0;
      e_reset = 1'b1; e_addr = '0; e_data = '0;
    end else if (!m_pend) begin
      if (wb_valid) begin
        e_grant = 1'b1; e_addr = wb_addr; e_data = wb_data;
      end
      if (mc_valid) begin
        m_pend = 1'b1; m_addr = mc_addr; m_data = mc_data; m_defers = 0;
      end
    end else if (m_defers == MAX_WAIT || !wb_valid) begin
      e_grant = 1'b1; e_addr = m_addr; e_data = m_data; m_pend = 1'b0;
    end else begin
      e_grant = 1'b1; e_addr = wb_addr; e_data = wb_data;
      if (wb_addr == m_addr) m_pend = 1'b0;
      else m_defers++;
    end
    e_we = e_grant && !(SUPPRESS && e_addr == 5'd0);
  endtask

  task automatic compare();
    chk("RegWrite", 32'(RegWrite), 32'(e_we));
    if (e_grant || e_reset) begin
      chk("write_register", 32'(write_register), 32'(e_addr));
      chk("write_data", write_data, e_data);
    end
    chk("mc_ready", 32'(mc_ready), 32'(!m_pend));
    chk("mc_pending", 32'(mc_pending), 32'(m_pend));
    chk("pipe_stall", 32'(pipe_stall), 32'(m_pend && m_defers == MAX_WAIT));
    chk("mc_pending_addr", 32'(mc_pending_addr), 32'(m_pend ? m_addr : 5'd0));
  endtask

  task automatic cycle(input logic wv, input logic [4:0] wa, input logic [31:0] wd,
                       input logic mv, input logic [4:0] ma, input logic [31:0] md);
    wb_valid = wv; wb_addr = wa; wb_data = wd;
    mc_valid = mv; mc_addr = ma; mc_data = md;
    @(posedge clk);
    model_step();
    #1;
    compare();
  endtask

  task automatic idle();
    cycle(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0);
  endtask

  initial begin
    rst_n = 1'b0;
    wb_valid = 1'b0; wb_addr = '0; wb_data = '0;
    mc_valid = 1'b0; mc_addr = '0; mc_data = '0;
    m_pend = 1'b0; m_addr = '0; m_data = '0; m_defers = 0;
    e_grant = 1'b0; e_reset = 1'b0; e_we = 1'b0; e_addr = '0; e_data = '0;
    #2;
    chk("reset RegWrite", 32'(RegWrite), 32'd0);
    chk("reset write_register", 32'(write_register), 32'd0);
    chk("reset write_data", write_data, 32'd0);
    chk("reset pipe_stall", 32'(pipe_stall), 32'd0);
    chk("reset mc_pending", 32'(mc_pending), 32'd0);
    chk("reset mc_ready", 32'(mc_ready), 32'd1);
    idle();
    rst_n = 1'b1;
    idle();

    // plain pipeline write
    cycle(1'b1, 5'd5, 32'hDEADBEEF, 1'b0, 5'd0, 32'd0);
    chk("wb RegWrite", 32'(RegWrite), 32'd1);
    chk("wb write_register", 32'(write_register), 32'd5);
    chk("wb write_data", write_data, 32'hDEADBEEF);
    idle();
    chk("idle RegWrite", 32'(RegWrite), 32'd0);

    // mc write drains when pipeline is quiet
    cycle(1'b0, 5'd0, 32'd0, 1'b1, 5'd9, 32'h1234);
    chk("mc hold mc_ready", 32'(mc_ready), 32'd0);
    chk("mc hold pending_addr", 32'(mc_pending_addr), 32'd9);
    idle();
    chk("mc drain RegWrite", 32'(RegWrite), 32'd1);
    chk("mc drain write_register", 32'(write_register), 32'd9);
    chk("mc drain write_data", write_data, 32'h1234);
    chk("mc drain mc_ready", 32'(mc_ready), 32'd1);

    // starvation: MAX_WAIT deferrals, then forced
    cycle(1'b0, 5'd0, 32'd0, 1'b1, 5'd9, 32'h5555);
    for (int i = 0; i < MAX_WAIT; i++) begin
      cycle(1'b1, 5'd3, 32'h300 + 32'(i), 1'b0, 5'd0, 32'd0);
      chk("defer write_register", 32'(write_register), 32'd3);
    end
    chk("force pipe_stall", 32'(pipe_stall), 32'd1);
    cycle(1'b1, 5'd3, 32'hBAD, 1'b0, 5'd0, 32'd0);
    chk("force write_register", 32'(write_register), 32'd9);
    chk("force write_data", write_data, 32'h5555);
    chk("after force pipe_stall", 32'(pipe_stall), 32'd0);
    idle();

    // younger same-address pipeline write discards the buffer
    cycle(1'b0, 5'd0, 32'd0, 1'b1, 5'd7, 32'h77);
    cycle(1'b1, 5'd7, 32'hAA, 1'b0, 5'd0, 32'd0);
    chk("same addr write_data", write_data, 32'hAA);
    chk("same addr mc_pending", 32'(mc_pending), 32'd0);
    idle();
    chk("discarded RegWrite", 32'(RegWrite), 32'd0);

    // simultaneous wb and mc in IDLE; mc offered while busy is ignored
    cycle(1'b1, 5'd4, 32'h44, 1'b1, 5'd10, 32'hA0);
    cycle(1'b1, 5'd2, 32'h22, 1'b1, 5'd12, 32'hC0);
    idle();
    chk("simul drain write_register", 32'(write_register), 32'd10);
    idle();
    idle();

    // asynchronous reset in HOLD drops the buffered write
    cycle(1'b0, 5'd0, 32'd0, 1'b1, 5'd11, 32'hB0);
    #2;
    rst_n = 1'b0;
    #1;
    chk("async rst RegWrite", 32'(RegWrite), 32'd0);
    chk("async rst mc_pending", 32'(mc_pending), 32'd0);
    chk("async rst mc_ready", 32'(mc_ready), 32'd1);
    idle();
    rst_n = 1'b1;
    idle();
    chk("post rst RegWrite", 32'(RegWrite), 32'd0);
    idle();

    // register 0 writes
    cycle(1'b1, 5'd0, 32'hFFFF, 1'b0, 5'd0, 32'd0);
    chk("zero wb RegWrite", 32'(RegWrite), SUPPRESS ? 32'd0 : 32'd1);
    chk("zero wb write_register", 32'(write_register), 32'd0);
    cycle(1'b0, 5'd0, 32'd0, 1'b1, 5'd0, 32'hE0);
    idle();
    chk("zero mc RegWrite", 32'(RegWrite), SUPPRESS ? 32'd0 : 32'd1);
    chk("zero mc mc_ready", 32'(mc_ready), 32'd1);
    idle();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire
